// File: rtl/vga_arb_pkg.sv
// Shared types and sizing for the VGA display-memory arbiter.
package vga_arb_pkg;

    localparam int ADDR_W           = 4;
    localparam int DATA_W           = 8;
    localparam int STARVE_W         = 10;
    localparam int STARVE_LIMIT_DEF = 800;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PEND      = 3'd1,
        ST_WR_SETUP  = 3'd2,
        ST_WR_COMMIT = 3'd3,
        ST_ACK       = 3'd4
    } arb_state_t;

endpackage

// File: rtl/vga_arb_starve_cnt.sv
// Saturating wait counter: raises force_wr once a pending write has waited LIMIT active-video cycles.
module vga_arb_starve_cnt
    import vga_arb_pkg::*;
#(
    parameter int LIMIT = STARVE_LIMIT_DEF
) (
    input  logic clk_sys,
    input  logic rst_b,
    input  logic incr,
    input  logic clr,
    output logic force_wr
);

    localparam logic [STARVE_W-1:0] LIMIT_V = STARVE_W'(LIMIT);

    logic [STARVE_W-1:0] cnt;

    always_ff @(posedge clk_sys or negedge rst_b) begin
        if (!rst_b) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (incr && (cnt != LIMIT_V)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign force_wr = (cnt == LIMIT_V);

endmodule

// File: rtl/vga_mem_arbiter.sv
// Shares one display-memory port between VGA reads and a blanking-time writer.
// Build option VGA_ARB_STARVE_FORCE_EN forces a write that has starved through active video.
module vga_mem_arbiter
    import vga_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              Blank,
    input  logic [ADDR_W-1:0] VgaAddr,
    output logic [DATA_W-1:0] VgaData,
    input  logic              WrReq,
    input  logic [ADDR_W-1:0] WrAddr,
    input  logic [DATA_W-1:0] WrData,
    output logic              WrAck,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [DATA_W-1:0] MemWrData,
    output logic              MemWE,
    input  logic [DATA_W-1:0] MemRdData,
    output logic              Busy
);

    // state        | meaning
    // ST_IDLE      | no request held; VGA owns the port
    // ST_PEND      | request latched, waiting for blanking (or force)
    // ST_WR_SETUP  | writer drives address/data, write not yet committed
    // ST_WR_COMMIT | MemWE pulse
    // ST_ACK       | WrAck held until the requester drops WrReq

    arb_state_t        state;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_data;
    logic              wr_own;
    logic              force_wr;

`ifdef VGA_ARB_STARVE_FORCE_EN
    logic starve_incr;
    logic starve_clr;

    assign starve_incr = (state == ST_PEND) && !Blank;
    // WR_COMMIT always leads to ACK, so clearing there clears on ACK entry.
    assign starve_clr  = (state == ST_IDLE) || (state == ST_WR_COMMIT);

    vga_arb_starve_cnt #(
        .LIMIT(STARVE_LIMIT)
    ) u_starve_cnt (
        .clk_sys  (CLK),
        .rst_b    (RESET),
        .incr     (starve_incr),
        .clr      (starve_clr),
        .force_wr (force_wr)
    );
`else
    assign force_wr = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state    <= ST_IDLE;
            lat_addr <= '0;
            lat_data <= '0;
            wr_own   <= 1'b0;
            MemWE    <= 1'b0;
            WrAck    <= 1'b0;
            Busy     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (WrReq) begin
                        lat_addr <= WrAddr;
                        lat_data <= WrData;
                        Busy     <= 1'b1;
                        state    <= ST_PEND;
                    end
                end
                ST_PEND: begin
                    if (Blank || force_wr) begin
                        wr_own <= 1'b1;
                        state  <= ST_WR_SETUP;
                    end
                end
                ST_WR_SETUP: begin
                    // Blanking ended before commit: give the port back and retry later.
                    if (!Blank && !force_wr) begin
                        wr_own <= 1'b0;
                        state  <= ST_PEND;
                    end else begin
                        MemWE <= 1'b1;
                        state <= ST_WR_COMMIT;
                    end
                end
                ST_WR_COMMIT: begin
                    MemWE  <= 1'b0;
                    wr_own <= 1'b0;
                    WrAck  <= 1'b1;
                    state  <= ST_ACK;
                end
                ST_ACK: begin
                    if (!WrReq) begin
                        WrAck <= 1'b0;
                        Busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    wr_own <= 1'b0;
                    MemWE  <= 1'b0;
                    WrAck  <= 1'b0;
                    Busy   <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            VgaData <= '0;
        end else if (!wr_own) begin
            VgaData <= MemRdData;
        end
    end

    assign MemAddr   = wr_own ? lat_addr : VgaAddr;
    assign MemWrData = lat_data;

endmodule

// File: doc/vga_mem_arbiter.md
VGA_MEM_ARBITER -- requirements
Module: vga_mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 800, cycles a pending write may wait during active video before forcing (used only with the starvation-force feature).
REQ-002 CLK  input  1  system clock, all logic rising-edge.
REQ-003 RESET  input  1  asynchronous, active-low reset.
REQ-004 Blank  input  1  high during horizontal/vertical blanking from the sync counters.
REQ-005 VgaAddr  input  4  display-memory address requested by the VGA pointer logic.
REQ-006 VgaData  output  8  registered read data returned to the VGA pointer logic.
REQ-007 WrReq  input  1  write request, four-phase level handshake.
REQ-008 WrAddr  input  4  write address, sampled at request capture.
REQ-009 WrData  input  8  write data, sampled at request capture.
REQ-010 WrAck  output  1  write-complete acknowledge, held until WrReq low.
REQ-011 MemAddr  output  4  shared display-memory address.
REQ-012 MemWrData  output  8  shared display-memory write data.
REQ-013 MemWE  output  1  display-memory write enable, one-cycle pulse.
REQ-014 MemRdData  input  8  display-memory combinational read data.
REQ-015 Busy  output  1  high whenever FSM not in IDLE.

Function
REQ-016 FSM states SHALL be IDLE, PEND, WR_SETUP, WR_COMMIT, ACK.
REQ-017 IDLE: WrReq=1 SHALL latch WrAddr/WrData into internal registers and go to PEND next cycle.
REQ-018 PEND: Blank=1 (or Force=1) SHALL go to WR_SETUP; otherwise remain.
REQ-019 WR_SETUP: Blank=0 and Force=0 SHALL abort back to PEND with no write; otherwise go to WR_COMMIT.
REQ-020 WR_COMMIT: MemWE=1 for exactly this cycle, then go to ACK unconditionally, even if Blank falls.
REQ-021 ACK: WrAck=1; WrReq=0 SHALL return to IDLE; WrReq held high SHALL hold ACK indefinitely.
REQ-022 MemAddr/MemWrData SHALL carry latched write address/data in WR_SETUP and WR_COMMIT; otherwise MemAddr=VgaAddr, MemWrData=latched data, MemWE=0.
REQ-023 VgaData SHALL load MemRdData on each cycle the VGA owns the port (1-cycle latency) and hold its prior value in WR_SETUP/WR_COMMIT.
REQ-024 Worst-case write latency from capture with Blank already high: 3 cycles to MemWE, 4 to WrAck.
REQ-025 A WrReq arriving while not in IDLE SHALL be ignored until IDLE; WrAddr/WrData changes after capture SHALL have no effect.

Reset
REQ-026 RESET low SHALL immediately force IDLE, VgaData=0, WrAck=0, MemWE=0, MemAddr=VgaAddr, Busy=0, latched registers=0, starvation count=0.
REQ-027 Reset mid-write (any state) SHALL discard the pending request with no write and no ack.

Configuration
REQ-028 Macro VGA_ARB_STARVE_FORCE_EN defined: a 10-bit counter SHALL increment each cycle in PEND with Blank=0, saturate at STARVE_LIMIT, assert Force while saturated, and clear on entering ACK or in IDLE.
REQ-029 Macro undefined: Force SHALL be constant 0, counter absent; writes occur only during Blank=1.

Structure
REQ-030 Shared package vga_arb_pkg SHALL hold the state enumeration, ADDR_W=4, DATA_W=8, STARVE_W=10, and the STARVE_LIMIT default.
REQ-031 Starvation counter SHALL be sub-module vga_arb_starve_cnt, instantiated only under VGA_ARB_STARVE_FORCE_EN.

Verification
REQ-032 Blank=1, WrReq=1 WrAddr=3 WrData=0xA5 -> MemWE pulse with MemAddr=3 MemWrData=0xA5 on cycle 3; WrAck cycle 4; IDLE one cycle after WrReq drops.
REQ-033 Blank=0, VgaAddr stepping 0..15, MemRdData=addr*0x11 -> VgaData=prior address*0x11 each cycle, MemWE never asserted.
REQ-034 Write pending with Blank=0, Blank rises for 1 cycle only (WR_SETUP) then falls -> abort to PEND, no MemWE; next blanking completes write.
REQ-035 Force enabled, STARVE_LIMIT=8, Blank held 0 -> MemWE asserted 11 cycles after capture; force disabled -> no write until Blank=1.
REQ-036 RESET low during WR_SETUP -> no MemWE, WrAck=0, Busy=0, VgaData=0 immediately; new request after release completes normally.
